// File: rtl/sf500_pkg.sv
// ============================================================================
// Module   : sf500_pkg
// Brief    : Shared state encoding, counter widths and helpers for the
//            68000 DMA bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sf500_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GRANT   = 3'd2,
        ST_OWNED   = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

    localparam int c_TO_CNT_W   = 8;
    localparam int c_TURN_CNT_W = 4;

    // Active-high one-hot of a 2-bit requester index (up to four requesters).
    function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_pick.sv
// ============================================================================
// Module   : rr_arb_pick
// Brief    : Combinational round-robin picker; search starts one past the
//            previous winner and wraps modulo NREQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic            any,
    output logic [1:0]      idx
);

    // Scan farthest offset first so the nearest requester after 'last' wins.
    always_comb begin
        any = 1'b0;
        idx = 2'd0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && (j == ((int'(last) + k) % NREQ))) begin
                    any = 1'b1;
                    idx = 2'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
// ============================================================================
// Module   : dma_bus_arbiter
// Brief    : 68000 three-wire bus arbitration between the local CPU and NREQ
//            external DMA masters. Optional grant timeout: ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_bus_arbiter
    import sf500_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TURN_CYC    = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            C14M,
    input  logic            RESET,
    input  logic [NREQ-1:0] BR_n,
    input  logic            BGACK_n,
    input  logic            BG_CPU_n,
    input  logic            AS_CPU_n,
    input  logic            DTACK_n,
    output logic            BR_CPU_n,
    output logic [NREQ-1:0] BG_n,
    output logic            DMA_ACTIVE,
    output logic [1:0]      GRANT_IDX,
    output logic            TIMEOUT
);

    localparam logic [1:0] c_LAST_RST = 2'(NREQ - 1);
    localparam logic [c_TURN_CNT_W-1:0] c_TURN_LAST = c_TURN_CNT_W'(TURN_CYC - 1);
    localparam logic [c_TO_CNT_W-1:0]   c_TO_LAST   = c_TO_CNT_W'(TIMEOUT_CYC - 1);

    logic [NREQ-1:0]         r_br_meta, r_br_sync;
    logic                    r_bgack_meta, r_bgack_sync;
    logic                    r_bgcpu_meta, r_bgcpu_sync;

    arb_state_t              r_state, w_state_nxt;
    logic                    r_br_cpu_n, w_br_cpu_n_nxt;
    logic [NREQ-1:0]         r_bg_n, w_bg_n_nxt;
    logic                    r_dma_active, w_dma_active_nxt;
    logic [1:0]              r_grant_idx, w_grant_idx_nxt;
    logic [1:0]              r_last, w_last_nxt;
    logic [c_TURN_CNT_W-1:0] r_turn_cnt, w_turn_cnt_nxt;

    logic                    w_pick_any;
    logic [1:0]              w_pick_idx;
    logic [3:0]              w_win_oh4;
    logic [NREQ-1:0]         w_win_oh;
    logic                    w_win_drop;
    logic                    w_cycle_done;
    logic                    w_to_hit;
    logic                    w_to_clr;

    rr_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req  (~r_br_sync),
        .last (r_last),
        .any  (w_pick_any),
        .idx  (w_pick_idx)
    );

    assign w_win_oh4    = idx_onehot(r_grant_idx);
    assign w_win_oh     = w_win_oh4[NREQ-1:0];
    assign w_win_drop   = ((r_br_sync & w_win_oh) != '0);
    // CPU has granted and its current bus cycle has fully terminated.
    assign w_cycle_done = !r_bgcpu_sync && AS_CPU_n && DTACK_n;

    always_comb begin
        w_state_nxt      = r_state;
        w_br_cpu_n_nxt   = r_br_cpu_n;
        w_bg_n_nxt       = r_bg_n;
        w_dma_active_nxt = r_dma_active;
        w_grant_idx_nxt  = r_grant_idx;
        w_last_nxt       = r_last;
        w_turn_cnt_nxt   = r_turn_cnt;
        w_to_clr         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_grant_idx_nxt = w_pick_idx;
                    w_br_cpu_n_nxt  = 1'b0;
                    w_state_nxt     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_win_drop) begin
                    w_br_cpu_n_nxt = 1'b1;
                    w_turn_cnt_nxt = '0;
                    w_state_nxt    = ST_RELEASE;
                end else if (w_cycle_done) begin
                    w_bg_n_nxt  = ~w_win_oh;
                    w_to_clr    = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!r_bgack_sync) begin
                    w_bg_n_nxt       = '1;
                    w_br_cpu_n_nxt   = 1'b1;
                    w_dma_active_nxt = 1'b1;
                    w_state_nxt      = ST_OWNED;
                end else if (w_win_drop || w_to_hit) begin
                    w_bg_n_nxt     = '1;
                    w_br_cpu_n_nxt = 1'b1;
                    w_turn_cnt_nxt = '0;
                    w_state_nxt    = ST_RELEASE;
                end
            end
            ST_OWNED: begin
                if (r_bgack_sync) begin
                    w_dma_active_nxt = 1'b0;
                    w_turn_cnt_nxt   = '0;
                    w_state_nxt      = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_br_cpu_n_nxt = 1'b1;
                w_bg_n_nxt     = '1;
                if (r_turn_cnt == c_TURN_LAST) begin
                    w_last_nxt  = r_grant_idx;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt + c_TURN_CNT_W'(1);
                end
            end
            default: begin
                w_br_cpu_n_nxt   = 1'b1;
                w_bg_n_nxt       = '1;
                w_dma_active_nxt = 1'b0;
                w_state_nxt      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge C14M) begin
        if (RESET) begin
            r_br_meta    <= '1;
            r_br_sync    <= '1;
            r_bgack_meta <= 1'b1;
            r_bgack_sync <= 1'b1;
            r_bgcpu_meta <= 1'b1;
            r_bgcpu_sync <= 1'b1;
            r_state      <= ST_IDLE;
            r_br_cpu_n   <= 1'b1;
            r_bg_n       <= '1;
            r_dma_active <= 1'b0;
            r_grant_idx  <= 2'd0;
            r_last       <= c_LAST_RST;
            r_turn_cnt   <= '0;
        end else begin
            r_br_meta    <= BR_n;
            r_br_sync    <= r_br_meta;
            r_bgack_meta <= BGACK_n;
            r_bgack_sync <= r_bgack_meta;
            r_bgcpu_meta <= BG_CPU_n;
            r_bgcpu_sync <= r_bgcpu_meta;
            r_state      <= w_state_nxt;
            r_br_cpu_n   <= w_br_cpu_n_nxt;
            r_bg_n       <= w_bg_n_nxt;
            r_dma_active <= w_dma_active_nxt;
            r_grant_idx  <= w_grant_idx_nxt;
            r_last       <= w_last_nxt;
            r_turn_cnt   <= w_turn_cnt_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [c_TO_CNT_W-1:0] r_to_cnt;
    logic                  r_timeout;

    assign w_to_hit = (r_state == ST_GRANT) && r_bgack_sync && !w_win_drop
                      && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge C14M) begin
        if (RESET) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (w_to_clr) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_GRANT) begin
                r_to_cnt <= r_to_cnt + c_TO_CNT_W'(1);
            end
        end
    end

    assign TIMEOUT = r_timeout;
`else
    logic w_unused_to;

    assign w_to_hit    = 1'b0;
    assign w_unused_to = ^{c_TO_LAST, w_to_clr};
    assign TIMEOUT     = 1'b0;
`endif

    assign BR_CPU_n   = r_br_cpu_n;
    assign BG_n       = r_bg_n;
    assign DMA_ACTIVE = r_dma_active;
    assign GRANT_IDX  = r_grant_idx;

endmodule

`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
// ============================================================================
// Module   : tb_dma_bus_arbiter
// Brief    : Self-checking bench for dma_bus_arbiter: directed handshakes and
//            randomized request patterns against a round-robin reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_bus_arbiter;

    localparam int NREQ        = 2;
    localparam int TURN_CYC    = 2;
    localparam int TIMEOUT_CYC = 255;
    localparam logic [NREQ-1:0] ALL1 = '1;

    logic            C14M     = 1'b0;
    logic            RESET    = 1'b1;
    logic [NREQ-1:0] BR_n     = '0;
    logic            BGACK_n  = 1'b1;
    logic            BG_CPU_n = 1'b1;
    logic            AS_CPU_n = 1'b1;
    logic            DTACK_n  = 1'b1;
    logic            BR_CPU_n;
    logic [NREQ-1:0] BG_n;
    logic            DMA_ACTIVE;
    logic [1:0]      GRANT_IDX;
    logic            TIMEOUT;

    int vectors     = 0;
    int miscompares = 0;
    int model_last  = NREQ - 1;

    dma_bus_arbiter #(
        .NREQ        (NREQ),
        .TURN_CYC    (TURN_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .C14M       (C14M),
        .RESET      (RESET),
        .BR_n       (BR_n),
        .BGACK_n    (BGACK_n),
        .BG_CPU_n   (BG_CPU_n),
        .AS_CPU_n   (AS_CPU_n),
        .DTACK_n    (DTACK_n),
        .BR_CPU_n   (BR_CPU_n),
        .BG_n       (BG_n),
        .DMA_ACTIVE (DMA_ACTIVE),
        .GRANT_IDX  (GRANT_IDX),
        .TIMEOUT    (TIMEOUT)
    );

    always #5 C14M = ~C14M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference round-robin: first requester after the previous winner, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] req, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (req[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] bg_for(input int w);
        logic [NREQ-1:0] v;
        v = ALL1;
        v[w] = 1'b0;
        return v;
    endfunction

    // One clock, then the always-true bus invariants.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge C14M);
            #1;
            chk("inv_bg_onehot", ($countones(~BG_n) <= 1) ? 1 : 0, 1);
            chk("inv_bg_needs_brcpu", ((BG_n != ALL1) && BR_CPU_n) ? 1 : 0, 0);
            chk("inv_dma_vs_bg", (DMA_ACTIVE && (BG_n != ALL1)) ? 1 : 0, 0);
`ifndef ARB_TIMEOUT_EN
            chk("inv_timeout_tied", TIMEOUT, 0);
`endif
        end
    endtask

    function automatic logic sel_sig(input int which);
        case (which)
            0:       return BR_CPU_n;
            1:       return DMA_ACTIVE;
            2:       return (BG_n != ALL1);
            default: return TIMEOUT;
        endcase
    endfunction

    task automatic wait_until(input int which, input logic val, input int bound,
                              input string tag, output int lat);
        bit got;
        got = 0;
        lat = 0;
        for (int k = 1; k <= bound && !got; k++) begin
            tick();
            if (sel_sig(which) === val) begin
                got = 1;
                lat = k;
            end
        end
        chk(tag, got, 1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_brcpu"}, BR_CPU_n, 1);
        chk({tag, "_bg"}, BG_n, ALL1);
        chk({tag, "_dma"}, DMA_ACTIVE, 0);
    endtask

    // mode 0: full ownership, 1: abandon in GRANT, 2: drop before CPU grant.
    task automatic run_txn(input logic [NREQ-1:0] req, input int mode, input int d, input int hold);
        int w, lat, exp_lat;
        bit got;
        w = rr_pick(req, model_last);
        BR_n = ~req;
        wait_until(0, 1'b0, 12, "br_cpu_fall_wait", lat);
        chk("br_cpu_fall_latency", lat, 3);
        chk("winner_idx", GRANT_IDX, w);
        if (mode == 2) begin
            BR_n = ALL1;
            tick(2);
            chk("req_drop_brcpu_held", BR_CPU_n, 0);
            tick();
            chk("req_drop_brcpu", BR_CPU_n, 1);
            chk("req_drop_bg", BG_n, ALL1);
        end else begin
            BG_CPU_n = 1'b0;
            AS_CPU_n = (d == 0);
            DTACK_n  = (d == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            got = 0;
            lat = 0;
            for (int k = 1; k <= d + 12 && !got; k++) begin
                tick();
                if (BG_n != ALL1) begin
                    got = 1;
                    lat = k;
                end else if (k <= d) begin
                    chk("bg_held_in_cycle", BG_n, ALL1);
                end
                if (k == d) begin
                    AS_CPU_n = 1'b1;
                    DTACK_n  = 1'b1;
                end
            end
            AS_CPU_n = 1'b1;
            DTACK_n  = 1'b1;
            exp_lat  = (d + 1 > 3) ? d + 1 : 3;
            chk("bg_fall_latency", lat, exp_lat);
            chk("bg_winner", BG_n, bg_for(w));
            if (mode == 1) begin
                BR_n = ALL1;
                tick(2);
                chk("abandon_bg_held", BG_n, bg_for(w));
                tick();
                chk("abandon_bg", BG_n, ALL1);
                chk("abandon_brcpu", BR_CPU_n, 1);
                chk("abandon_dma", DMA_ACTIVE, 0);
                BG_CPU_n = 1'b1;
            end else begin
                BGACK_n = 1'b0;
                BR_n    = ALL1;
                tick(2);
                chk("own_dma_pre", DMA_ACTIVE, 0);
                tick();
                chk("own_dma", DMA_ACTIVE, 1);
                chk("own_bg", BG_n, ALL1);
                chk("own_brcpu", BR_CPU_n, 1);
                BG_CPU_n = 1'b1;
                for (int k = 0; k < hold; k++) begin
                    tick();
                    chk("own_hold_dma", DMA_ACTIVE, 1);
                end
                BGACK_n = 1'b1;
                tick(2);
                chk("own_end_dma_held", DMA_ACTIVE, 1);
                tick();
                chk("own_end_dma", DMA_ACTIVE, 0);
            end
        end
        model_last = w;
        tick(6);
        chk_quiet("txn_quiet");
    endtask

    initial begin
        int w, lat;

        // Reset held with both requests asserted.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_quiet("reset_hold");
        end
        RESET = 1'b0;
        tick();
        chk_quiet("reset_after");
        chk("reset_grant_idx", GRANT_IDX, 0);
        chk("reset_timeout", TIMEOUT, 0);

        // Round-robin with both requests held continuously.
        wait_until(0, 1'b0, 10, "rr_first_req_wait", lat);
        chk("rr_first_req_latency", lat, 2);
        for (int n = 0; n < 3; n++) begin
            w = rr_pick(ALL1, model_last);
            chk("rr_grant_idx", GRANT_IDX, w);
            BG_CPU_n = 1'b0;
            wait_until(2, 1'b1, 10, "rr_bg_wait", lat);
            chk("rr_bg", BG_n, bg_for(w));
            BGACK_n = 1'b0;
            wait_until(1, 1'b1, 10, "rr_dma_wait", lat);
            BG_CPU_n = 1'b1;
            tick(3);
            BGACK_n = 1'b1;
            wait_until(1, 1'b0, 10, "rr_dma_end_wait", lat);
            model_last = w;
            wait_until(0, 1'b0, 10, "rr_turnaround_wait", lat);
            chk("rr_turnaround", lat, TURN_CYC + 1);
        end

        // Reset while a grant is outstanding withdraws it on the next edge.
        w = rr_pick(ALL1, model_last);
        chk("rr_fourth_idx", GRANT_IDX, w);
        BG_CPU_n = 1'b0;
        wait_until(2, 1'b1, 10, "midreset_bg_wait", lat);
        RESET    = 1'b1;
        BR_n     = ALL1;
        BG_CPU_n = 1'b1;
        tick();
        chk_quiet("midreset");
        chk("midreset_idx", GRANT_IDX, 0);
        RESET = 1'b0;
        model_last = NREQ - 1;
        tick(4);
        chk_quiet("midreset_after");

        // Directed handshakes: single request, cycle in flight, abandon.
        run_txn(2'b01, 0, 2, 4);
        run_txn(2'b11, 0, 10, 3);
        run_txn(2'b10, 1, 0, 0);
        run_txn(2'b11, 2, 0, 0);

        // Randomized request patterns and handshake timings.
        for (int t = 0; t < 20; t++) begin
            run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
                    int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 6)),
                    int'($urandom_range(1, 6)));
        end

`ifdef ARB_TIMEOUT_EN
        // Grant abandoned by the timeout; the other requester is served next.
        BR_n = '0;
        w = rr_pick(ALL1, model_last);
        wait_until(0, 1'b0, 12, "to_req_wait", lat);
        chk("to_idx", GRANT_IDX, w);
        BG_CPU_n = 1'b0;
        wait_until(2, 1'b1, 10, "to_bg_wait", lat);
        wait_until(3, 1'b1, TIMEOUT_CYC + 20, "to_pulse_wait", lat);
        chk("to_latency", lat, TIMEOUT_CYC);
        chk("to_bg", BG_n, ALL1);
        chk("to_brcpu", BR_CPU_n, 1);
        chk("to_dma", DMA_ACTIVE, 0);
        tick();
        chk("to_pulse_width", TIMEOUT, 0);
        BG_CPU_n = 1'b1;
        model_last = w;
        w = rr_pick(ALL1, model_last);
        wait_until(0, 1'b0, 12, "to_next_wait", lat);
        chk("to_next_idx", GRANT_IDX, w);
        BR_n = ALL1;
        model_last = w;
        tick(6);
        chk_quiet("to_quiet");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
